// File: rtl/fuego_pkg.sv
// Shared constants for the fire-alarm evaluator: channel indices, FSM encodings
// and the sample width.
package fuego_pkg;

  localparam int W = 11;

  localparam logic [1:0] CH_T_ALTA  = 2'd0;
  localparam logic [1:0] CH_T_MEDIA = 2'd1;
  localparam logic [1:0] CH_HUMO    = 2'd2;
  localparam logic [1:0] CH_ELEC    = 2'd3;

  typedef enum logic [1:0] {
    NORMAL     = 2'b00,
    PRECAUCION = 2'b01,
    INCENDIO   = 2'b10,
    ESPERA_ACK = 2'b11
  } estado_t;

endpackage

// File: rtl/filtro_canal.sv
// Per-channel persistence filter: a flag sets after N_ACT consecutive
// over-threshold samples and clears after N_DES consecutive ones at/under it.
module filtro_canal #(
  parameter int N_ACT = 4,
  parameter int N_DES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic actualizar,
  input  logic over,
  output logic flag
);

  localparam logic [3:0] ACT_C = 4'(N_ACT);
  localparam logic [3:0] DES_C = 4'(N_DES);

  logic [3:0] cnt;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt + 4'd1;

  // cnt counts samples that disagree with the current flag; an agreeing sample restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (actualizar) begin
      if (flag == over) begin
        cnt <= '0;
      end else if (cnt_inc == (flag ? DES_C : ACT_C)) begin
        flag <= ~flag;
        cnt  <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/evaluador_alarmas.sv
// Fire-alarm evaluator: demultiplexes the sensor stream, debounces each channel
// against its threshold and runs the fire-control FSM that drives the actuators.
module evaluador_alarmas
  import fuego_pkg::*;
#(
  parameter logic [W-1:0] UMBRAL_T_ALTA  = 11'd600,
  parameter logic [W-1:0] UMBRAL_T_MEDIA = 11'd400,
  parameter logic [W-1:0] UMBRAL_HUMO    = 11'd300,
  parameter logic [W-1:0] UMBRAL_ELEC    = 11'd900,
  parameter int           N_ACT          = 4,
  parameter int           N_DES          = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] dato_in,
  input  logic [1:0]   canal,
  input  logic         dato_valido,
  input  logic         ack_alarma,
  output logic [3:0]   flags,
  output logic [1:0]   estado,
  output logic         alarma,
  output logic         rociadores,
  output logic         ventilacion,
  output logic         corte_elec
);

  localparam logic [3:0][W-1:0] UMBRAL = {UMBRAL_ELEC, UMBRAL_HUMO, UMBRAL_T_MEDIA, UMBRAL_T_ALTA};

  logic [3:0] over;
  logic       fuego;
  logic       aviso;
  estado_t    st;

  for (genvar i = 0; i < 4; i++) begin : g_canal
    assign over[i] = dato_in > UMBRAL[i];
    filtro_canal #(.N_ACT(N_ACT), .N_DES(N_DES)) u_filtro (
      .clk        (clk),
      .reset      (reset),
      .actualizar (dato_valido && (canal == 2'(i))),
      .over       (over[i]),
      .flag       (flags[i])
    );
  end

  // Elec is deliberately left out of the FSM; it only forces the mains cut-off
  assign fuego = flags[CH_T_ALTA] | (flags[CH_T_MEDIA] & flags[CH_HUMO]);
  assign aviso = flags[CH_T_MEDIA] | flags[CH_HUMO];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= NORMAL;
    end else begin
      case (st)
        NORMAL:     if (fuego) st <= INCENDIO; else if (aviso) st <= PRECAUCION;
        PRECAUCION: if (fuego) st <= INCENDIO; else if (!aviso) st <= NORMAL;
        INCENDIO:   if (!fuego) st <= ESPERA_ACK;
        ESPERA_ACK: if (fuego) st <= INCENDIO; else if (ack_alarma) st <= NORMAL;
        default:    st <= NORMAL;
      endcase
    end
  end

  // Decoded from registers only, so an async reset silences every actuator at once
  assign estado      = st;
  assign alarma      = (st == INCENDIO) || (st == ESPERA_ACK);
  assign rociadores  = (st == INCENDIO);
  assign ventilacion = (st == PRECAUCION);
  assign corte_elec  = (st == INCENDIO) || flags[CH_ELEC];

endmodule
